// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD display stages: field widths, seven-segment
// glyphs and a small digit-validity helper.
package bcd_pkg;

   localparam int SEG_W = 7;
   localparam int BCD_W = 4;

   // Glyph bit order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

   function automatic logic bcdInvalid(input logic [BCD_W-1:0] digit);
      return digit > BCD_W'(9);
   endfunction

endpackage

// File: rtl/bcd_scan_display_if.sv
// Load handshake and display outputs of the scanned seven-segment driver.
interface bcd_scan_display_if #(
   parameter int NDIG = 2
);
   import bcd_pkg::*;

   logic                    load_valid;
   logic                    load_ready;
   logic [BCD_W*NDIG-1:0]   bcd_in;
   logic [SEG_W-1:0]        seg;
   logic [NDIG-1:0]         an;
   logic                    err;

   modport master (
      output load_valid,
      output bcd_in,
      input  load_ready,
      input  seg,
      input  an,
      input  err
   );

   modport slave (
      input  load_valid,
      input  bcd_in,
      output load_ready,
      output seg,
      output an,
      output err
   );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to seven-segment glyph; nibbles above 9 render as a dash.
module bcd_to_7seg
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   output logic [SEG_W-1:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed seven-segment driver: a pending word is swapped into the
// display register only at frame boundaries so a scan frame never tears.
module bcd_scan_display
   import bcd_pkg::*;
#(
   parameter int NDIG     = 2,
   parameter int PRESCALE = 4,
   parameter int BLANK_LZ = 1
)
(
   input  logic               clk,
   input  logic               rst,
   bcd_scan_display_if.slave  bus
);

   localparam int PCW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IDXW  = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int WORDW = BCD_W * NDIG;

   logic [PCW-1:0]   pcnt;
   logic [IDXW-1:0]  idx;
   logic [WORDW-1:0] pend;
   logic [WORDW-1:0] disp;
   logic             pend_full;
   logic             errFlag;

   logic             pcntWrap;
   logic             frameEnd;
   logic             accept;
   logic             pendBad;
   logic [BCD_W-1:0] curDigit;
   logic [NDIG-1:0]  anNext;
   logic [SEG_W-1:0] glyph;
   logic             blankNow;
   logic [SEG_W-1:0] segReg;
   logic [NDIG-1:0]  anReg;

   assign pcntWrap       = (pcnt == PCW'(PRESCALE - 1));
   assign frameEnd       = pcntWrap && (idx == IDXW'(NDIG - 1));
   assign accept         = bus.load_valid && !pend_full;
   assign bus.load_ready = !pend_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt <= '0;
         idx  <= '0;
      end else if (pcntWrap) begin
         pcnt <= '0;
         idx  <= (idx == IDXW'(NDIG - 1)) ? '0 : idx + IDXW'(1);
      end else begin
         pcnt <= pcnt + PCW'(1);
      end
   end

   always_comb begin
      pendBad = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (bcdInvalid(pend[i*BCD_W +: BCD_W])) pendBad = 1'b1;
      end
   end

   // A frame-boundary transfer takes priority; load_ready is low then anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         pend_full <= 1'b0;
         disp      <= '0;
         errFlag   <= 1'b0;
      end else if (frameEnd && pend_full) begin
         disp      <= pend;
         pend_full <= 1'b0;
         if (pendBad) errFlag <= 1'b1;
      end else if (accept) begin
         pend      <= bus.bcd_in;
         pend_full <= 1'b1;
      end
   end

   always_comb begin
      curDigit = '0;
      anNext   = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx == IDXW'(i)) begin
            curDigit  = disp[i*BCD_W +: BCD_W];
            anNext[i] = 1'b1;
         end
      end
   end

   // Digit i>0 is blank when it and all higher digits are zero; bad nibbles count as non-zero.
   always_comb begin
      blankNow = 1'b0;
      for (int i = 1; i < NDIG; i++) begin
         if (idx == IDXW'(i)) begin
            blankNow = (BLANK_LZ != 0);
            for (int j = i; j < NDIG; j++) begin
               if (disp[j*BCD_W +: BCD_W] != '0) blankNow = 1'b0;
            end
         end
      end
   end

   bcd_to_7seg u_decode (
      .digit (curDigit),
      .seg   (glyph)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         segReg <= '0;
         anReg  <= '0;
      end else begin
         segReg <= blankNow ? '0 : glyph;
         anReg  <= anNext;
      end
   end

   assign bus.seg = segReg;
   assign bus.an  = anReg;
   assign bus.err = errFlag;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display (NDIG=2, PRESCALE=4): dutA blanks
// leading zeros, dutB does not; expectations are keyed by posedge count.
module tb_bcd_scan_display;
   import bcd_pkg::*;

   typedef enum int {K_AN, K_SEG, K_ERR, K_RDY, K_SEGB, K_ANB} kind_t;

   typedef struct {
      int          cyc;
      string       name;
      kind_t       kind;
      logic [7:0]  want;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       loadValid;
   logic [7:0] bcdIn;

   int   cycCount   = 0;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   always @(posedge clk) cycCount <= cycCount + 1;

   bcd_scan_display_if #(.NDIG(2)) busA ();
   bcd_scan_display_if #(.NDIG(2)) busB ();

   assign busA.load_valid = loadValid;
   assign busA.bcd_in     = bcdIn;
   assign busB.load_valid = loadValid;
   assign busB.bcd_in     = bcdIn;

   bcd_scan_display #(.NDIG(2), .PRESCALE(4), .BLANK_LZ(1)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (busA)
   );

   bcd_scan_display #(.NDIG(2), .PRESCALE(4), .BLANK_LZ(0)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (busB)
   );

   function automatic logic [7:0] sampleKind(input kind_t kind);
      case (kind)
         K_AN:    return {6'b0, busA.an};
         K_SEG:   return {1'b0, busA.seg};
         K_ERR:   return {7'b0, busA.err};
         K_RDY:   return {7'b0, busA.load_ready};
         K_SEGB:  return {1'b0, busB.seg};
         K_ANB:   return {6'b0, busB.an};
         default: return 8'hFF;
      endcase
   endfunction

   // Queue an expectation for the negedge following posedge number cyc.
   task automatic checkOutput(input int cyc, input string name, input kind_t kind,
                              input logic [7:0] want);
      exp_t e;
      int   pos;
      e.cyc  = cyc;
      e.name = name;
      e.kind = kind;
      e.want = want;
      pos    = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > cyc) begin
            pos = i;
            break;
         end
      end
      sb.insert(pos, e);
   endtask

   task automatic waitCycle(input int cyc);
      while (cycCount < cyc) @(negedge clk);
   endtask

   task automatic applyStimulus(input int cyc, input logic [7:0] word);
      waitCycle(cyc);
      loadValid = 1'b1;
      bcdIn     = word;
      waitCycle(cyc + 1);
      loadValid = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t       e;
      logic [7:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cycCount) begin
         e   = sb.pop_front();
         act = sampleKind(e.kind);
         compared = compared + 1;
         if (e.cyc < cycCount) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: stale check for cycle %0d seen at cycle %0d", e.name, e.cyc, cycCount);
         end else if (act !== e.want) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", e.name, cycCount, act, e.want);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      loadValid = 1'b0;
      bcdIn     = 8'h00;

      checkOutput(2,  "reset_an",     K_AN,   8'h00);
      checkOutput(2,  "reset_seg",    K_SEG,  8'h00);
      checkOutput(2,  "reset_segB",   K_SEGB, 8'h00);
      checkOutput(2,  "reset_err",    K_ERR,  8'h00);
      checkOutput(2,  "reset_rdy",    K_RDY,  8'h01);
      checkOutput(3,  "first_an",     K_AN,   8'h01);
      checkOutput(3,  "first_seg",    K_SEG,  8'h3F);
      checkOutput(6,  "d0_hold_an",   K_AN,   8'h01);
      checkOutput(7,  "d1_an",        K_AN,   8'h02);
      checkOutput(7,  "zero_blank",   K_SEG,  8'h00);
      checkOutput(7,  "zero_noblank", K_SEGB, 8'h3F);
      checkOutput(10, "d1_hold_an",   K_AN,   8'h02);
      checkOutput(11, "wrap_an",      K_AN,   8'h01);
      checkOutput(11, "wrap_anB",     K_ANB,  8'h01);
      waitCycle(2);
      rst = 1'b0;
      $display("[TB] reset released");

      checkOutput(12, "load23_busy",  K_RDY, 8'h00);
      checkOutput(17, "load23_wait",  K_RDY, 8'h00);
      checkOutput(18, "load23_rdy",   K_RDY, 8'h01);
      checkOutput(18, "no_tear_seg",  K_SEG, 8'h00);
      checkOutput(19, "load23_d0_an", K_AN,  8'h01);
      checkOutput(19, "load23_d0",    K_SEG, 8'h4F);
      checkOutput(23, "load23_d1_an", K_AN,  8'h02);
      checkOutput(23, "load23_d1",    K_SEG, 8'h5B);
      applyStimulus(11, 8'h23);

      checkOutput(26, "old_word_held", K_SEG,  8'h5B);
      checkOutput(27, "load07_d0",     K_SEG,  8'h07);
      checkOutput(27, "load07_d0B",    K_SEGB, 8'h07);
      checkOutput(31, "load07_d1_an",  K_AN,   8'h02);
      checkOutput(31, "load07_blank",  K_SEG,  8'h00);
      checkOutput(31, "load07_noblk",  K_SEGB, 8'h3F);
      applyStimulus(19, 8'h07);

      checkOutput(33, "err_before",    K_ERR,  8'h00);
      checkOutput(34, "err_at_xfer",   K_ERR,  8'h01);
      checkOutput(35, "load1A_dash",   K_SEG,  8'h40);
      checkOutput(39, "load1A_d1",     K_SEG,  8'h06);
      checkOutput(39, "load1A_d1B",    K_SEGB, 8'h06);
      applyStimulus(27, 8'h1A);

      checkOutput(43, "load05_d0",     K_SEG,  8'h6D);
      checkOutput(47, "load05_blank",  K_SEG,  8'h00);
      checkOutput(47, "load05_noblk",  K_SEGB, 8'h3F);
      checkOutput(47, "err_sticky",    K_ERR,  8'h01);
      applyStimulus(35, 8'h05);

      checkOutput(44, "b2b_busy",      K_RDY, 8'h00);
      checkOutput(49, "b2b_wait",      K_RDY, 8'h00);
      checkOutput(50, "b2b_rdy",       K_RDY, 8'h01);
      checkOutput(50, "b2b_old_d1",    K_SEG, 8'h00);
      checkOutput(51, "b2b_acc22",     K_RDY, 8'h00);
      checkOutput(51, "b2b_11_d0",     K_SEG, 8'h06);
      checkOutput(58, "b2b_11_d1",     K_SEG, 8'h06);
      checkOutput(59, "b2b_22_an",     K_AN,  8'h01);
      checkOutput(59, "b2b_22_d0",     K_SEG, 8'h5B);
      checkOutput(63, "b2b_22_d1",     K_SEG, 8'h5B);
      waitCycle(43);
      loadValid = 1'b1;
      bcdIn     = 8'h11;
      waitCycle(44);
      bcdIn     = 8'h22;
      waitCycle(51);
      loadValid = 1'b0;

      checkOutput(61, "mid_pending",   K_RDY, 8'h00);
      checkOutput(64, "mid_frame_an",  K_AN,  8'h02);
      checkOutput(64, "mid_frame_seg", K_SEG, 8'h5B);
      checkOutput(65, "rst2_an",       K_AN,  8'h00);
      checkOutput(65, "rst2_seg",      K_SEG, 8'h00);
      checkOutput(65, "rst2_err",      K_ERR, 8'h00);
      checkOutput(65, "rst2_rdy",      K_RDY, 8'h01);
      checkOutput(66, "rst2_d0_an",    K_AN,  8'h01);
      checkOutput(66, "rst2_d0",       K_SEG, 8'h3F);
      checkOutput(70, "rst2_d1",       K_SEG, 8'h00);
      checkOutput(74, "no_99_d0",      K_SEG, 8'h3F);
      checkOutput(75, "no_99_rdy",     K_RDY, 8'h01);
      applyStimulus(59, 8'h99);
      waitCycle(64);
      rst = 1'b1;
      waitCycle(65);
      rst = 1'b0;

      waitCycle(80);
      @(posedge clk);
      while (sb.size() > 0) begin
         exp_t left;
         left = sb.pop_front();
         compared   = compared + 1;
         mismatched = mismatched + 1;
         $display("[TB] FAIL %s: never checked, expected 0x%0h at cycle %0d", left.name, left.want, left.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed seven-segment driver that consumes packed BCD digits from the binary-to-BCD converter stage and drives a common-anode-style digit strobe and segment bus. It accepts a new BCD word through a valid/ready handshake into a pending register, swaps it into the display register only at a scan-frame boundary so the display never tears, and scans one digit at a time using a prescaler. Leading-zero blanking and invalid-digit flagging are applied on the way out.

## Interface
- `NDIG`, default 2: number of BCD digits scanned.
- `PRESCALE`, default 4: clock cycles each digit is held. Legal range is 1 or more.
- `BLANK_LZ`, default 1: when 1, leading-zero blanking is enabled.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `load_valid`  in  1  `bcd_in` carries a word to display.
- `load_ready`  out  1  pending register is empty; a word is accepted when `load_valid` and `load_ready` are both high.
- `bcd_in`  in  4*NDIG  packed BCD digits; digit 0 (ones) is at [3:0]. The converter's 2-bit tens output is zero-extended to [7:4].
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-high.
- `an`  out  NDIG  one-hot digit enable, active-high.
- `err`  out  1  sticky flag: a displayed word contained a nibble greater than 9.

## Operation
- State:
  - prescaler `pcnt` counts 0..PRESCALE-1;
  - digit index `idx` counts 0..NDIG-1;
  - pending register `pend` with flag `pend_full`;
  - display register `disp`.
- Prescaler:
  - `pcnt` increments every cycle and wraps to 0 after PRESCALE-1.
  - `idx` increments on that wrap; it wraps from NDIG-1 to 0.
- Frame boundary: the cycle in which `idx` is NDIG-1 and `pcnt` is PRESCALE-1.
- Load handshake:
  - `load_ready` equals `!pend_full`.
  - On acceptance: `pend` takes `bcd_in` and `pend_full` goes to 1.
- Transfer:
  - At a frame boundary with `pend_full` set: `disp` takes `pend` and `pend_full` clears.
  - If any nibble of `pend` is greater than 9, `err` sets in the same cycle.
- Simultaneous load and boundary: when `pend_full` is 0 there is nothing to transfer. The accepted word sits in `pend` until the next boundary, one full frame later.
- Decode:
  - Digit values 0-9 use the standard glyphs: 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F.
  - Nibbles 10-15 show a dash, 0x40.
- Blanking (BLANK_LZ=1):
  - Digit i > 0 outputs `seg` = 0 when that digit and every higher digit are zero.
  - Digit 0 is never blanked.
  - A nibble greater than 9 counts as non-zero.
  - `an` is still asserted for a blanked digit.
- Reset:
  - `pcnt`=0, `idx`=0, `disp`=0, `pend_full`=0, `err`=0.
  - `seg`=0 and `an`=0.
  - `load_ready` is 1 from the first cycle after reset.
  - Reset mid-frame or mid-pending discards the pending word, with no transfer.
- `err` clears only on reset.

## Timing
- `seg` and `an` are registered:
  - `an` equals onehot(`idx`) and `seg` equals decode(`disp`[`idx`]), both as of the previous cycle (one-cycle latency).
  - The first cycle after reset release gives `an`=1, showing digit 0.
- Frame length is NDIG×PRESCALE cycles; each digit is asserted for exactly PRESCALE consecutive cycles.
- Load-to-display latency depends on the phase at acceptance:
  - minimum 1 cycle to the boundary, plus 1 cycle of output register;
  - maximum NDIG×PRESCALE + 1 cycles.
- A new `disp` value first appears on the digit-0 output, one cycle after the boundary.
- `load_ready` falls the cycle after acceptance and rises the cycle after the transfer boundary.
- Back-to-back loads therefore sustain at most one word per frame.

## Structure
- Shared package `bcd_pkg` holds:
  - the glyph constants `SEG_0`..`SEG_9` and `SEG_DASH`;
  - `SEG_W` = 7;
  - `BCD_W` = 4.
- Sub-module `bcd_to_7seg` is purely combinational: 4-bit digit in, 7-bit glyph out. It is reusable by other display stages.
- Top level holds the prescaler, index counter, pending/display registers, blanking logic and output registers.

## Test plan
All scenarios use NDIG=2, PRESCALE=4.
- **Reset:** `rst` high for 2 cycles → `seg`=0, `an`=0, `err`=0, `load_ready`=1. Next cycle `an`=01; then `an` alternates 01/10 every 4 cycles.
- **Basic load:** load 0x23 → after the boundary, `an`=01 gives `seg`=0x4F and `an`=10 gives `seg`=0x5B. `load_ready` returns to 1.
- **Blanking:** load 0x07 → digit 0 shows 0x07 and digit 1 shows `seg`=0x00 with `an`=10. Repeat with BLANK_LZ=0 → digit 1 shows 0x3F.
- **Invalid digit:** load 0x1A → digit 0 shows 0x40 and digit 1 shows 0x06. `err`=1 from the boundary and stays 1 after a later load of 0x05.
- **Back-to-back:** load 0x11, then hold `load_valid` with 0x22 → `load_ready`=0 until the boundary. 0x22 is accepted the cycle after and displayed one frame later. 0x11 is shown for exactly one frame.
- **Reset mid-frame:** with `idx`=1, `pcnt`=2 and `pend_full`=1 holding 0x99, assert `rst` → the display resumes at digit 0 showing 0x3F. 0x99 never appears.
